// File: rtl/tlul_slave_responder.sv
// TL-UL slave endpoint backed by a word-addressed register memory, one outstanding request.
// Define TLUL_RESP_STALL_EN to add LFSR-driven pseudo-random A-channel backpressure.
module tlul_slave_responder #(
    parameter int unsigned DATA_WIDTH                = 32,
    parameter int unsigned ADDR_WIDTH                = 32,
    parameter int unsigned MASK_WIDTH                = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH                = 3,
    parameter int unsigned SRC_WIDTH                 = 2,
    parameter int unsigned SINK_WIDTH                = 1,
    parameter int unsigned OPCODE_WIDTH              = 3,
    parameter int unsigned PARAM_WIDTH               = 3,
    parameter int unsigned DEPTH_WORDS               = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h0000_0000),
    parameter int unsigned RESP_LATENCY              = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_a_valid,
    output logic                    o_a_ready,
    input  logic [OPCODE_WIDTH-1:0] i_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  i_a_param,
    input  logic [SIZE_WIDTH-1:0]   i_a_size,
    input  logic [SRC_WIDTH-1:0]    i_a_source,
    input  logic [ADDR_WIDTH-1:0]   i_a_address,
    input  logic [MASK_WIDTH-1:0]   i_a_mask,
    input  logic [DATA_WIDTH-1:0]   i_a_data,
    output logic                    o_d_valid,
    input  logic                    i_d_ready,
    output logic [OPCODE_WIDTH-1:0] o_d_opcode,
    output logic [PARAM_WIDTH-1:0]  o_d_param,
    output logic [SIZE_WIDTH-1:0]   o_d_size,
    output logic [SRC_WIDTH-1:0]    o_d_source,
    output logic [SINK_WIDTH-1:0]   o_d_sink,
    output logic [DATA_WIDTH-1:0]   o_d_data,
    output logic                    o_d_error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned SPAN_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W  = (RESP_LATENCY > 2) ? $clog2(RESP_LATENCY - 1) : 1;

    localparam logic [SPAN_W-1:0]       SPAN     = SPAN_W'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0]        CNT_INIT = (RESP_LATENCY >= 2) ? CNT_W'(RESP_LATENCY - 2)
                                                                       : '0;
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK       = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] D_ACK_DATA  = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_d_valid;
    logic [OPCODE_WIDTH-1:0] r_d_opcode;
    logic [SIZE_WIDTH-1:0]   r_d_size;
    logic [SRC_WIDTH-1:0]    r_d_source;
    logic [DATA_WIDTH-1:0]   r_d_data;
    logic                    r_d_error;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_in_range;
    logic                    w_size_err;
    logic                    w_misaligned;
    logic                    w_is_get;
    logic                    w_is_put;
    logic                    w_err;
    logic                    w_accept;
    logic                    w_wr_en;
    logic                    w_stall_ok;
    logic                    w_unused;

`ifdef TLUL_RESP_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall_ok = r_lfsr[0];
`else
    assign w_stall_ok = 1'b1;
`endif

    // Offset wraps for addresses below the base, so one unsigned compare covers both bounds.
    assign w_offset   = i_a_address - BASE_ADDR;
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_in_range = {1'b0, w_offset} < SPAN;
    assign w_size_err = i_a_size > SIZE_WIDTH'(2);
    assign w_is_get   = i_a_opcode == OP_GET;
    assign w_is_put   = (i_a_opcode == OP_PUT_FULL) || (i_a_opcode == OP_PUT_PART);
    assign w_err      = !w_in_range || w_size_err || w_misaligned || !(w_is_get || w_is_put);

    always_comb begin
        w_misaligned = 1'b0;
        case (i_a_size)
            SIZE_WIDTH'(1): w_misaligned = i_a_address[0];
            SIZE_WIDTH'(2): w_misaligned = |i_a_address[1:0];
            default:        w_misaligned = 1'b0;
        endcase
    end

    assign o_a_ready = (r_state == StIdle) && !i_reset && w_stall_ok;
    assign w_accept  = i_a_valid && o_a_ready;
    assign w_wr_en   = w_accept && w_is_put && !w_err;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < int'(MASK_WIDTH); i++) begin
                if (i_a_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_d_opcode <= w_is_get ? D_ACK_DATA : D_ACK;
                        r_d_size   <= i_a_size;
                        r_d_source <= i_a_source;
                        r_d_error  <= w_err;
                        r_d_data   <= (w_is_get && !w_err) ? r_mem[w_idx] : '0;
                        if (RESP_LATENCY == 1) begin
                            r_state   <= StResp;
                            r_d_valid <= 1'b1;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        r_state   <= StResp;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StResp: begin
                    if (i_d_ready) begin
                        r_state   <= StIdle;
                        r_d_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_d_valid  = r_d_valid;
    assign o_d_opcode = r_d_opcode;
    assign o_d_param  = '0;
    assign o_d_size   = r_d_size;
    assign o_d_source = r_d_source;
    assign o_d_sink   = '0;
    assign o_d_data   = r_d_data;
    assign o_d_error  = r_d_error;

    assign w_unused = ^i_a_param;

endmodule

// File: tb/tb_tlul_slave_responder.sv
// Randomized self-checking bench for tlul_slave_responder (RESP_LATENCY=3) against a
// transaction-level model; directed cases pin the model with literal expectations.
module tb_tlul_slave_responder;

    localparam int L = 3;
    localparam longint unsigned BASE  = 0;
    localparam longint unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_a_valid = 1'b0;
    logic        o_a_ready;
    logic [2:0]  i_a_opcode = '0;
    logic [2:0]  i_a_param = '0;
    logic [2:0]  i_a_size = '0;
    logic [1:0]  i_a_source = '0;
    logic [31:0] i_a_address = '0;
    logic [3:0]  i_a_mask = '0;
    logic [31:0] i_a_data = '0;
    logic        o_d_valid;
    logic        i_d_ready = 1'b1;
    logic [2:0]  o_d_opcode;
    logic [2:0]  o_d_param;
    logic [2:0]  o_d_size;
    logic [1:0]  o_d_source;
    logic [0:0]  o_d_sink;
    logic [31:0] o_d_data;
    logic        o_d_error;

    always #5 clk = ~clk;

    tlul_slave_responder #(
        .RESP_LATENCY(L)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_a_valid   (i_a_valid),
        .o_a_ready   (o_a_ready),
        .i_a_opcode  (i_a_opcode),
        .i_a_param   (i_a_param),
        .i_a_size    (i_a_size),
        .i_a_source  (i_a_source),
        .i_a_address (i_a_address),
        .i_a_mask    (i_a_mask),
        .i_a_data    (i_a_data),
        .o_d_valid   (o_d_valid),
        .i_d_ready   (i_d_ready),
        .o_d_opcode  (o_d_opcode),
        .o_d_param   (o_d_param),
        .o_d_size    (o_d_size),
        .o_d_source  (o_d_source),
        .o_d_sink    (o_d_sink),
        .o_d_data    (o_d_data),
        .o_d_error   (o_d_error)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // d_ready: 0 = random, 1 = held low, otherwise held high
    int dr_mode = 2;
    always @(posedge clk) begin
        #1;
        case (dr_mode)
            0:       i_d_ready = ($urandom_range(0, 3) != 0);
            1:       i_d_ready = 1'b0;
            default: i_d_ready = 1'b1;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic [31:0] data;
        bit          err;
        bit          dknown;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [DEPTH];
    bit          mdef [DEPTH];
    bit          busy = 0;
    bit          mon_en = 0;
    int          cyc = 0;

    // Model: one transaction at a time; outputs judged every cycle from accept time and queue.
    always @(negedge clk) begin
        exp_t            e;
        longint unsigned a;
        int              idx;
        bit              err;
        bit              exp_dv;
        cyc++;
        if (mon_en) begin
            chk("a_ready", o_a_ready, !busy && !i_reset);
            exp_dv = busy && q.size() > 0 && (cyc - q[0].acc >= L);
            chk("d_valid", o_d_valid, exp_dv);
            if (o_d_valid && q.size() > 0) begin
                chk("d_opcode", o_d_opcode, q[0].op);
                chk("d_size", o_d_size, q[0].size);
                chk("d_source", o_d_source, q[0].src);
                chk("d_error", o_d_error, q[0].err);
                chk("d_param", o_d_param, 0);
                chk("d_sink", o_d_sink, 0);
                if (q[0].dknown) chk("d_data", o_d_data, q[0].data);
            end
            if (o_d_valid && i_d_ready && !i_reset && q.size() > 0) begin
                void'(q.pop_front());
                busy = 0;
            end
            if (o_a_ready && i_a_valid && !i_reset) begin
                a   = i_a_address;
                err = !(a >= BASE && a < BASE + 4 * DEPTH) || i_a_size > 2 ||
                      !(i_a_opcode inside {3'd0, 3'd1, 3'd4});
                if (i_a_size <= 2 && (a % (64'd1 << i_a_size)) != 0) err = 1;
                idx      = int'(((a - BASE) >> 2) % DEPTH);
                e.op     = (i_a_opcode == 3'd4) ? 3'd1 : 3'd0;
                e.size   = i_a_size;
                e.src    = i_a_source;
                e.err    = err;
                e.acc    = cyc;
                e.data   = '0;
                e.dknown = 1;
                if (i_a_opcode == 3'd4 && !err) begin
                    e.data   = mmem[idx];
                    e.dknown = mdef[idx];
                end
                if ((i_a_opcode == 3'd0 || i_a_opcode == 3'd1) && !err) begin
                    for (int b = 0; b < 4; b++)
                        if (i_a_mask[b]) mmem[idx][8*b +: 8] = i_a_data[8*b +: 8];
                    if (i_a_mask == 4'hF) mdef[idx] = 1;
                end
                q.push_back(e);
                busy = 1;
            end
            if (i_reset) begin
                q.delete();
                busy = 0;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        bit acc = 0;
        i_a_opcode  = op;
        i_a_param   = 3'($urandom);
        i_a_size    = sz;
        i_a_source  = src;
        i_a_address = addr;
        i_a_mask    = mask;
        i_a_data    = data;
        i_a_valid   = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (o_a_ready) acc = 1;
        end
        @(posedge clk);
        #1;
        i_a_valid = 1'b0;
        chk("a_accept", acc, 1);
    endtask

    task automatic txn(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       output logic [2:0] rop, output logic [31:0] rdata, output logic rerr,
                       output logic [1:0] rsrc);
        bit got = 0;
        rop = '0; rdata = '0; rerr = 1'b0; rsrc = '0;
        send(op, sz, src, addr, mask, data);
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (o_d_valid && i_d_ready) begin
                got   = 1;
                rop   = o_d_opcode;
                rdata = o_d_data;
                rerr  = o_d_error;
                rsrc  = o_d_source;
            end
        end
        chk("resp_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] rd;
        logic        rerr;
        logic [1:0]  rsrc;
        logic [2:0]  op, sz;
        logic [31:0] addr;
        logic [2:0]  bad_ops [5];
        int          k;
        bit          seen;
        bad_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", o_a_ready, 0);
        chk("rst_d_valid", o_d_valid, 0);
        chk("rst_d_opcode", o_d_opcode, 0);
        chk("rst_d_data", o_d_data, 0);
        chk("rst_d_error", o_d_error, 0);
        chk("rst_d_size", o_d_size, 0);
        chk("rst_d_source", o_d_source, 0);
        chk("rst_d_param", o_d_param, 0);
        chk("rst_d_sink", o_d_sink, 0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", o_a_ready, 1);
        mon_en = 1;
        @(posedge clk);
        #1;

        txn(3'd0, 3'd2, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, rop, rd, rerr, rsrc);
        chk("put_opcode", rop, 0);
        chk("put_error", rerr, 0);
        chk("put_source", rsrc, 2);
        txn(3'd4, 3'd2, 2'd1, 32'h10, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("get_opcode", rop, 1);
        chk("get_data", rd, 32'hDEADBEEF);
        txn(3'd1, 3'd2, 2'd0, 32'h10, 4'b0101, 32'h11223344, rop, rd, rerr, rsrc);
        txn(3'd4, 3'd2, 2'd0, 32'h10, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("partial_data", rd, 32'hDE22BE44);

        txn(3'd0, 3'd2, 2'd0, 32'h0, 4'hF, 32'h01234567, rop, rd, rerr, rsrc);
        txn(3'd4, 3'd2, 2'd3, 32'h400, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("oor_get_opcode", rop, 1);
        chk("oor_get_error", rerr, 1);
        chk("oor_get_data", rd, 0);
        txn(3'd0, 3'd2, 2'd0, 32'h400, 4'hF, 32'hFFFFFFFF, rop, rd, rerr, rsrc);
        chk("oor_put_error", rerr, 1);
        txn(3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("oor_put_no_write", rd, 32'h01234567);

        txn(3'd4, 3'd2, 2'd0, 32'h2, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("misalign_error", rerr, 1);
        chk("misalign_data", rd, 0);
        txn(3'd5, 3'd2, 2'd1, 32'h10, 4'hF, 32'h0, rop, rd, rerr, rsrc);
        chk("badop_opcode", rop, 0);
        chk("badop_error", rerr, 1);
        txn(3'd0, 3'd2, 2'd0, 32'h3FC, 4'hF, 32'hAABBCCDD, rop, rd, rerr, rsrc);
        chk("top_word_put_error", rerr, 0);
        txn(3'd4, 3'd2, 2'd0, 32'h3FC, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("top_word_get", rd, 32'hAABBCCDD);

        // Backpressure: response must appear L cycles after accept and hold until d_ready.
        dr_mode = 1;
        @(posedge clk);
        #1;
        send(3'd4, 3'd2, 2'd2, 32'h10, 4'h0, 32'h0);
        k = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (o_d_valid) seen = 1;
        end
        chk("bp_latency", k, L);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", o_d_valid, 1);
            chk("bp_hold_data", o_d_data, 32'hDE22BE44);
        end
        dr_mode = 2;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (o_d_valid && i_d_ready) seen = 1;
        end
        chk("bp_handshake", seen, 1);
        @(negedge clk);
        chk("bp_a_ready_after", o_a_ready, 1);
        @(posedge clk);
        #1;

        // Reset while waiting: response dropped, write retained.
        send(3'd0, 3'd2, 2'd1, 32'h20, 4'hF, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("rstwait_d_valid", o_d_valid, 0);
        chk("rstwait_a_ready", o_a_ready, 1);
        @(posedge clk);
        #1;
        txn(3'd4, 3'd2, 2'd1, 32'h20, 4'h0, 32'h0, rop, rd, rerr, rsrc);
        chk("rstwait_get", rd, 32'hCAFEF00D);

        for (int w = 0; w < int'(DEPTH); w++)
            send(3'd0, 3'd2, 2'(w), 32'(w * 4), 4'hF, $urandom);

        dr_mode = 0;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 99);
            if (k < 40) op = 3'd4;
            else if (k < 65) op = 3'd0;
            else if (k < 90) op = 3'd1;
            else op = bad_ops[$urandom_range(0, 4)];
            sz = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(0, 3));
            else if (sz == 3'd1) addr = addr | (32'($urandom_range(0, 1)) << 1);
            else if (sz == 3'd0) addr = addr | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = 32'h400 + 32'($urandom_range(0, 65535));
            send(op, sz, 2'($urandom), addr, 4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        dr_mode = 2;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("drain", busy, 0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlul_slave_responder.md
# tlul_slave_responder

- Synthesizable TL-UL slave endpoint. Accepts A-channel requests, services them from an internal word-addressed register memory, and returns D-channel responses.
- Intended as the memory-backed target behind the single-slave port of the interconnect, in both simulation benches and FPGA bring-up.
- Supports Get, PutFullData and PutPartialData, with one outstanding transaction and a configurable response latency.

## Interface
- DATA_WIDTH, 32: data bus width; must be 32.
- ADDR_WIDTH, 32: address width.
- MASK_WIDTH, DATA_WIDTH/8: byte-mask width.
- SIZE_WIDTH, 3: a_size/d_size width.
- SRC_WIDTH, 2: source ID width.
- SINK_WIDTH, 1: sink ID width.
- OPCODE_WIDTH, 3: opcode width.
- PARAM_WIDTH, 3: param width.
- DEPTH_WORDS, 256: memory depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte base address; aligned to DEPTH_WORDS*4.
- RESP_LATENCY, 1: cycles from A-accept edge to d_valid; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  request valid.
- a_ready  out  1  request accept.
- a_opcode  in  OPCODE_WIDTH  0=PutFullData, 1=PutPartialData, 4=Get.
- a_param  in  PARAM_WIDTH  ignored.
- a_size  in  SIZE_WIDTH  log2 bytes.
- a_source  in  SRC_WIDTH  requester ID.
- a_address  in  ADDR_WIDTH  byte address.
- a_mask  in  MASK_WIDTH  byte enables.
- a_data  in  DATA_WIDTH  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accept.
- d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData.
- d_param  out  PARAM_WIDTH  always 0.
- d_size  out  SIZE_WIDTH  echo of a_size.
- d_source  out  SRC_WIDTH  echo of a_source.
- d_sink  out  SINK_WIDTH  always 0.
- d_data  out  DATA_WIDTH  read data; 0 for AccessAck or on error.
- d_error  out  1  denied/corrupt response.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: a_ready=1 (see Configuration).
  - On a_valid&&a_ready, latch opcode/size/source and evaluate the error condition.
  - Go to RESP if RESP_LATENCY==1; otherwise go to WAIT with cnt=RESP_LATENCY-2.
- WAIT: a_ready=0. Decrement cnt; go to RESP when cnt==0.
- RESP: d_valid=1 and all d_* outputs stable. On d_ready, go to IDLE.
- Error is set when any of the following holds; an errored request causes no memory write and returns d_data=0:
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4);
  - a_size>2;
  - address not aligned to 2^a_size;
  - opcode not in {0,1,4}.
- Response opcode:
  - Get → AccessAckData.
  - Puts and unsupported opcodes → AccessAck.
- Writes are committed at the accept edge: every byte i with a_mask[i]=1 is written. PutFullData and PutPartialData are treated identically.
- Get data is sampled from memory at the accept edge: the full word, mask ignored. A read therefore observes all earlier writes.
- Word index = (a_address-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- Memory contents are not reset.

## Timing
- Reset values: a_ready=0 during reset, and 1 in the first IDLE cycle after release (subject to Configuration). d_valid=0, d_opcode=0, d_param=0, d_size=0, d_source=0, d_sink=0, d_data=0, d_error=0.
- Latency: with a request accepted at edge t, d_valid rises after edge t+RESP_LATENCY-1, i.e. it is visible in cycle t+RESP_LATENCY.
- d_valid never drops without d_ready. d_* outputs do not change while d_valid=1 and d_ready=0.
- a_ready is 0 from the accept edge until the cycle after the D handshake. Peak throughput is 1 transaction per RESP_LATENCY+1 cycles.
- d_ready high before d_valid has no effect.
- a_valid in WAIT/RESP is not accepted; the requester holds it.
- Reset asserted mid-transaction: FSM→IDLE and d_valid=0 on the next edge; the pending response is dropped. A write committed at accept is retained.

## Configuration
- TLUL_RESP_STALL_EN defined: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle. In IDLE, a_ready=lfsr[0]; the LFSR gives pseudo-random A backpressure for bench stress.
- Undefined: no LFSR; a_ready=1 whenever the FSM is in IDLE.

## Test plan
- Put/Get: PutFullData addr 0x10, data 0xDEADBEEF, mask 4'hF, source 2 → AccessAck, error 0, source 2. Then Get 0x10 → AccessAckData, data 0xDEADBEEF.
- Partial write: PutPartialData addr 0x10, data 0x11223344, mask 4'b0101 over 0xDEADBEEF → a subsequent Get returns 0xDE22BE44.
- Out-of-range: Get addr BASE_ADDR+0x400 (DEPTH_WORDS=256) → AccessAckData, d_error=1, d_data=0. Put to the same address → d_error=1, memory unchanged.
- Misaligned and unsupported requests: Get addr 0x2 size 2 → d_error=1. Opcode 5 → AccessAck with d_error=1.
- Backpressure: RESP_LATENCY=3, d_ready held low 5 cycles after d_valid → d_valid rises 3 cycles after accept, and outputs stay stable until d_ready. a_ready returns 1 the cycle after the handshake.
- Reset in WAIT: assert reset 1 cycle after a Put accept → d_valid stays 0 and a_ready=1 after release. A subsequent Get returns the written data.
